// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch controller: FSM state encoding and the
// default values for PC width, reset/start address and the halt opcode.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int         PC_W_DEF        = 8;
  localparam logic [7:0] START_ADDR_DEF  = 8'h00;
  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC generation for the fetch controller.
//   pc_i          : current fetch PC
//   inst_pc_i     : PC of the instruction currently offered to decode
//   jump_i        : absolute redirect request
//   jump_target_i : absolute redirect target
//   branch_i      : relative redirect request (jump_i has priority)
//   branch_off_i  : signed 8-bit offset applied to inst_pc_i
//   seq_pc_o      : pc_i + 1 (sequential fetch)
//   redir_pc_o    : PC to load after a handshake (jump, branch or pc_i)
// All arithmetic wraps modulo 2^PC_W.
// -----------------------------------------------------------------------------
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] inst_pc_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_i,
  input  logic [7:0]      branch_off_i,
  output logic [PC_W-1:0] seq_pc_o,
  output logic [PC_W-1:0] redir_pc_o
);

  logic signed [7:0]      off_s;
  logic        [PC_W-1:0] branch_pc;

  assign off_s     = branch_off_i;
  // Size cast of a signed operand sign-extends (or truncates) to PC_W.
  assign branch_pc = inst_pc_i + PC_W'(off_s);
  assign seq_pc_o  = pc_i + PC_W'(1);

  always_comb begin
    if (jump_i) begin
      redir_pc_o = jump_target_i;
    end else if (branch_i) begin
      redir_pc_o = branch_pc;
    end else begin
      redir_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller: reads a combinational ROM one word per FETCH
// cycle, offers the word to decode with a valid/ready handshake, applies
// jump/branch redirects on the handshake and stops on the halt opcode.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_n_i        : synchronous active-low reset
//   start_i        : start fetching at START_ADDR (from IDLE or HALT)
//   rom_addr_o     : ROM address (always the current PC)
//   rom_data_i     : ROM word for rom_addr_o, same cycle
//   inst_o         : registered instruction to decode
//   inst_pc_o      : address inst_o came from
//   inst_valid_o   : inst_o/inst_pc_o valid
//   inst_ready_i   : decode accepts inst_o
//   jump_i         : absolute redirect on handshake
//   jump_target_i  : absolute redirect target
//   branch_i       : relative redirect on handshake
//   branch_off_i   : signed offset from inst_pc_o
//   halted_o       : fetch stopped on HALT_OPCODE
//   retired_o      : handshake count (only with FETCH_CTRL_PERF_EN)
//
// Build option
//   FETCH_CTRL_PERF_EN : when defined, retired_o is a saturating 16-bit count
//                        of handshakes; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR  = PC_W'(START_ADDR_DEF),
  parameter logic [7:0]      HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  output logic [PC_W-1:0] rom_addr_o,
  input  logic [7:0]      rom_data_i,
  output logic [7:0]      inst_o,
  output logic [PC_W-1:0] inst_pc_o,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_i,
  input  logic [7:0]      branch_off_i,
  output logic            halted_o,
  output logic [15:0]     retired_o
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] HALT  = ST_HALT;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic [PC_W-1:0] seq_pc, redir_pc;
  logic            handshake;

  assign handshake = (state_q == ISSUE) && inst_ready_i;

  fetch_next_pc #(
    .PC_W(PC_W)
  ) u_next_pc (
    .pc_i          (pc_q),
    .inst_pc_i     (inst_pc_q),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .branch_i      (branch_i),
    .branch_off_i  (branch_off_i),
    .seq_pc_o      (seq_pc),
    .redir_pc_o    (redir_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          pc_d    = START_ADDR;
          state_d = FETCH;
        end
      end
      FETCH: begin
        inst_d    = rom_data_i;
        inst_pc_d = pc_q;
        // On halt the PC stays on the halt word so it is visible on rom_addr_o.
        if (rom_data_i == HALT_OPCODE) begin
          state_d = HALT;
        end else begin
          pc_d    = seq_pc;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Redirects only take effect on the handshake cycle.
        if (inst_ready_i) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      inst_q    <= 8'h00;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (handshake && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      retired_q <= 16'h0000;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = 16'h0000;
`endif

  assign rom_addr_o   = pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = (state_q == ISSUE);
  assign halted_o     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl with default parameters. Directed
// scenarios followed by a randomized handshake/redirect run checked against a
// transaction-level model (next issued PC = jump target, branch PC, or +1).
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, ready, jump, branch;
  logic [7:0]  target, off;
  logic [7:0]  rom_addr, rom_data, inst, inst_pc;
  logic        valid, halted;
  logic [15:0] retired;
  logic [7:0]  rom [256];

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_valid_o  (valid),
    .inst_ready_i  (ready),
    .jump_i        (jump),
    .jump_target_i (target),
    .branch_i      (branch),
    .branch_off_i  (off),
    .halted_o      (halted),
    .retired_o     (retired)
  );

  function automatic logic [15:0] exp_retired();
    return PERF ? 16'(exp_ret) : 16'h0000;
  endfunction

  // Architectural rule for the next issued address, in plain integer math.
  function automatic logic [7:0] model_next(input logic [7:0] ipc, input bit j,
                                            input logic [7:0] t, input bit b,
                                            input logic [7:0] o);
    int sum;
    if (j) return t;
    if (b) sum = int'(ipc) + int'($signed(o));
    else   sum = int'(ipc) + 1;
    sum = ((sum % 256) + 256) % 256;
    return 8'(sum);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; ready = 0; jump = 0; branch = 0; target = 8'h00; off = 8'h00;
  endtask

  // Handshake in ISSUE with the given redirect, then let the refetch complete.
  task automatic accept(input bit j, input logic [7:0] t, input bit b, input logic [7:0] o);
    ready = 1; jump = j; target = t; branch = b; off = o;
    step();
    exp_ret++;
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    rst_n = 0; start = 1; jump = 1; branch = 1; ready = 1;
    step(); step();
    idle_inputs(); rst_n = 1;
    exp_ret = 0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    total++; if (inst !== 8'h00) begin bad++; $display("FAIL reset_inst: got %h want 00", inst); end
    total++; if (inst_pc !== 8'h00) begin bad++; $display("FAIL reset_inst_pc: got %h want 00", inst_pc); end
    total++; if (retired !== 16'h0) begin bad++; $display("FAIL reset_retired: got %h want 0000", retired); end
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL idle_hold_valid: got %b want 0", valid); end
  endtask

  task automatic test_first_fetch();
    rom[8'h00] = 8'hC0;
    start = 1;
    step();
    start = 0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL fetch_valid: got %b want 0", valid); end
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL fetch_rom_addr: got %h want 00", rom_addr); end
    step();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", valid); end
    total++; if (inst !== 8'hC0) begin bad++; $display("FAIL first_inst: got %h want C0", inst); end
    total++; if (inst_pc !== 8'h00) begin bad++; $display("FAIL first_inst_pc: got %h want 00", inst_pc); end
    total++; if (rom_addr !== 8'h01) begin bad++; $display("FAIL first_rom_addr: got %h want 01", rom_addr); end
    accept(0, 8'h00, 0, 8'h00);
    total++; if (inst_pc !== 8'h01) begin bad++; $display("FAIL second_inst_pc: got %h want 01", inst_pc); end
    total++; if (inst !== rom[8'h01]) begin bad++; $display("FAIL second_inst: got %h want %h", inst, rom[8'h01]); end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      ready = 0; jump = 1'($urandom); branch = 1'($urandom);
      target = 8'($urandom); off = 8'($urandom); start = (k == 2);
      step();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", k, valid); end
      total++; if (inst_pc !== 8'h01) begin bad++; $display("FAIL stall_inst_pc[%0d]: got %h want 01", k, inst_pc); end
      total++; if (inst !== rom[8'h01]) begin bad++; $display("FAIL stall_inst[%0d]: got %h want %h", k, inst, rom[8'h01]); end
      total++; if (rom_addr !== 8'h02) begin bad++; $display("FAIL stall_pc[%0d]: got %h want 02", k, rom_addr); end
      total++; if (retired !== exp_retired()) begin bad++; $display("FAIL stall_retired[%0d]: got %0d want %0d", k, retired, exp_retired()); end
    end
    idle_inputs();
    accept(0, 8'h00, 0, 8'h00);
    total++; if (inst_pc !== 8'h02) begin bad++; $display("FAIL post_stall_pc: got %h want 02", inst_pc); end
  endtask

  task automatic test_jump();
    accept(1, 8'h0D, 0, 8'h00);
    total++; if (inst_pc !== 8'h0D) begin bad++; $display("FAIL jump_0d: got %h want 0D", inst_pc); end
    total++; if (inst !== rom[8'h0D]) begin bad++; $display("FAIL jump_0d_inst: got %h want %h", inst, rom[8'h0D]); end
    accept(1, 8'h0B, 0, 8'h00);
    total++; if (inst_pc !== 8'h0B) begin bad++; $display("FAIL jump_0b: got %h want 0B", inst_pc); end
    accept(1, 8'h40, 1, 8'h05);
    total++; if (inst_pc !== 8'h40) begin bad++; $display("FAIL jump_priority: got %h want 40", inst_pc); end
  endtask

  task automatic test_branch_wrap();
    accept(1, 8'h01, 0, 8'h00);
    accept(0, 8'h00, 1, 8'hFE);
    total++; if (inst_pc !== 8'hFF) begin bad++; $display("FAIL branch_back: got %h want FF", inst_pc); end
    accept(0, 8'h00, 0, 8'h00);
    total++; if (inst_pc !== 8'h00) begin bad++; $display("FAIL seq_wrap: got %h want 00", inst_pc); end
    total++; if (inst !== rom[8'h00]) begin bad++; $display("FAIL seq_wrap_inst: got %h want %h", inst, rom[8'h00]); end
    accept(1, 8'h02, 0, 8'h00);
    accept(0, 8'h00, 1, 8'hFC);
    total++; if (inst_pc !== 8'hFE) begin bad++; $display("FAIL branch_fc: got %h want FE", inst_pc); end
  endtask

  task automatic test_halt();
    rom[8'h0E] = 8'hFF;
    accept(1, 8'h0D, 0, 8'h00);
    accept(0, 8'h00, 0, 8'h00);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", halted); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL halt_valid: got %b want 0", valid); end
    for (int k = 0; k < 3; k++) begin
      ready = 1; jump = 1; target = 8'h33;
      step();
      total++; if (rom_addr !== 8'h0E) begin bad++; $display("FAIL halt_pc_frozen[%0d]: got %h want 0E", k, rom_addr); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_stays[%0d]: got %b want 1", k, halted); end
    end
    idle_inputs();
    start = 1;
    step();
    start = 0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL restart_halted: got %b want 0", halted); end
    step();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL restart_valid: got %b want 1", valid); end
    total++; if (inst_pc !== 8'h00) begin bad++; $display("FAIL restart_pc: got %h want 00", inst_pc); end
    rom[8'h0E] = 8'h3C;
  endtask

  task automatic test_reset_mid();
    ready = 1; jump = 1; target = 8'h55; start = 1;
    rst_n = 0;
    step();
    exp_ret = 0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", valid); end
    total++; if (inst !== 8'h00) begin bad++; $display("FAIL mid_reset_inst: got %h want 00", inst); end
    total++; if (inst_pc !== 8'h00) begin bad++; $display("FAIL mid_reset_inst_pc: got %h want 00", inst_pc); end
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL mid_reset_pc: got %h want 00", rom_addr); end
    total++; if (retired !== 16'h0) begin bad++; $display("FAIL mid_reset_retired: got %h want 0000", retired); end
    rst_n = 1; idle_inputs();
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_reset_idle: got %b want 0", valid); end
    start = 1; step(); start = 0; step();
    for (int k = 0; k < 3; k++) accept(0, 8'h00, 0, 8'h00);
    total++; if (retired !== (PERF ? 16'd3 : 16'd0)) begin bad++; $display("FAIL retired_three: got %0d want %0d", retired, (PERF ? 3 : 0)); end
    total++; if (inst_pc !== 8'h03) begin bad++; $display("FAIL after_three_pc: got %h want 03", inst_pc); end
  endtask

  task automatic test_random();
    bit         exp_valid = 1'b1;
    logic [7:0] exp_pc    = 8'h03;
    bit         r, j, b, hs;
    logic [7:0] t, o;
    for (int n = 0; n < 400; n++) begin
      r = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      t = 8'($urandom); o = 8'($urandom);
      ready = r; jump = j; branch = b; target = t; off = o;
      start = 1'($urandom_range(0, 1));
      hs = exp_valid && r;
      if (hs) begin
        exp_pc = model_next(exp_pc, j, t, b, o);
        exp_ret++;
      end
      exp_valid = !hs;
      step();
      total++; if (valid !== exp_valid) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, valid, exp_valid); end
      if (exp_valid) begin
        total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL rand_pc[%0d]: got %h want %h", n, inst_pc, exp_pc); end
        total++; if (inst !== rom[exp_pc]) begin bad++; $display("FAIL rand_inst[%0d]: got %h want %h", n, inst, rom[exp_pc]); end
      end
    end
    idle_inputs();
    total++; if (retired !== exp_retired()) begin bad++; $display("FAIL rand_retired: got %0d want %0d", retired, exp_retired()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 254));
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump();
    test_branch_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
